alu_issue_stage: RTL and testbench

ID/EX issue stage for the pipelined MIPS core: it is the producer side of the ALU control/operand interface. It decodes opcode/funct into the 4-bit ALU control code, selects and extends operands, and registers them into the EX stage. It enforces multi-cycle occupancy of the EX stage for multiply and handles downstream stall and pipeline flush. All ALU-facing outputs are registered.

---
 rtl/alu_issue_stage_if.sv | 37 +++
 rtl/alu_issue_stage.sv | 177 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage_if
// Description : ID-side handshake plus EX-side ALU control/operand bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_stage_if;
    logic        id_valid;
    logic        id_ready;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [15:0] id_imm;
    logic        ex_stall;
    logic        flush;
    logic        ex_valid;
    logic [3:0]  ex_aluctl;
    logic [31:0] ex_in1;
    logic [31:0] ex_in2;
    logic        ex_illegal;
    logic        mult_busy;

    // master: the issue stage (producer of the ALU operand bundle)
    modport master (
        input  id_valid, id_opcode, id_funct, id_rs_data, id_rt_data, id_imm,
        input  ex_stall, flush,
        output id_ready, ex_valid, ex_aluctl, ex_in1, ex_in2, ex_illegal, mult_busy
    );

    modport slave (
        output id_valid, id_opcode, id_funct, id_rs_data, id_rt_data, id_imm,
        output ex_stall, flush,
        input  id_ready, ex_valid, ex_aluctl, ex_in1, ex_in2, ex_illegal, mult_busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : ID/EX issue stage: decodes opcode/funct into ALU control,
//               selects operands and holds EX for multi-cycle multiplies.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int MULT_CYCLES = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    alu_issue_stage_if.master bus
);

    localparam int CNT_RAW = $clog2(MULT_CYCLES) + 1;
    localparam int CNT_W   = (CNT_RAW < 3) ? 3 : CNT_RAW;

    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    localparam logic [3:0] C_ALU_ADD  = 4'b0010;
    localparam logic [3:0] C_ALU_SUB  = 4'b0110;
    localparam logic [3:0] C_ALU_AND  = 4'b0000;
    localparam logic [3:0] C_ALU_OR   = 4'b0001;
    localparam logic [3:0] C_ALU_XOR  = 4'b1111;
    localparam logic [3:0] C_ALU_NOR  = 4'b1100;
    localparam logic [3:0] C_ALU_SLT  = 4'b0111;
    localparam logic [3:0] C_ALU_MULT = 4'b1000;
    localparam logic [3:0] C_ALU_NOP  = 4'b0011;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        MULT = 1'b1
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ex_valid_q;
    logic [3:0]       aluctl_q;
    logic [31:0]      in1_q;
    logic [31:0]      in2_q;
    logic             illegal_q;

    logic [3:0]       aluctl_d;
    logic [31:0]      in1_d;
    logic [31:0]      in2_d;
    logic             illegal_d;
    logic             is_mult_d;
    logic             w_accept;

    wire logic [31:0] w_imm_sext = {{16{bus.id_imm[15]}}, bus.id_imm};
    wire logic [31:0] w_imm_zext = {16'h0000, bus.id_imm};

    always_comb begin
        aluctl_d  = C_ALU_NOP;
        in2_d     = 32'h0;
        illegal_d = 1'b0;
        is_mult_d = 1'b0;
        unique case (bus.id_opcode)
            6'h00: begin
                in2_d = bus.id_rt_data;
                unique case (bus.id_funct)
                    6'h20: aluctl_d = C_ALU_ADD;
                    6'h22: aluctl_d = C_ALU_SUB;
                    6'h24: aluctl_d = C_ALU_AND;
                    6'h25: aluctl_d = C_ALU_OR;
                    6'h26: aluctl_d = C_ALU_XOR;
                    6'h27: aluctl_d = C_ALU_NOR;
                    6'h2A: aluctl_d = C_ALU_SLT;
                    6'h18: begin
                        aluctl_d  = C_ALU_MULT;
                        is_mult_d = 1'b1;
                    end
                    default: illegal_d = 1'b1;
                endcase
            end
            6'h08, 6'h23, 6'h2B: begin
                aluctl_d = C_ALU_ADD;
                in2_d    = w_imm_sext;
            end
            6'h0A: begin
                aluctl_d = C_ALU_SLT;
                in2_d    = w_imm_sext;
            end
            6'h0C: begin
                aluctl_d = C_ALU_AND;
                in2_d    = w_imm_zext;
            end
            6'h0D: begin
                aluctl_d = C_ALU_OR;
                in2_d    = w_imm_zext;
            end
            6'h0E: begin
                aluctl_d = C_ALU_XOR;
                in2_d    = w_imm_zext;
            end
            6'h04, 6'h05: begin
                aluctl_d = C_ALU_SUB;
                in2_d    = bus.id_rt_data;
            end
            default: illegal_d = 1'b1;
        endcase
        // Illegal instructions still occupy EX but carry neutral operands
        if (illegal_d) begin
            aluctl_d  = C_ALU_NOP;
            in2_d     = 32'h0;
            is_mult_d = 1'b0;
        end
        in1_d = illegal_d ? 32'h0 : bus.id_rs_data;
    end

    assign bus.id_ready = (state_q == RUN) && !bus.ex_stall && !bus.flush && rst_n;
    assign w_accept     = bus.id_valid && bus.id_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            ex_valid_q <= 1'b0;
            aluctl_q   <= C_ALU_NOP;
            in1_q      <= 32'h0;
            in2_q      <= 32'h0;
            illegal_q  <= 1'b0;
        end else if (bus.flush) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            ex_valid_q <= 1'b0;
            aluctl_q   <= C_ALU_NOP;
            in1_q      <= 32'h0;
            in2_q      <= 32'h0;
            illegal_q  <= 1'b0;
        end else if (!bus.ex_stall) begin
            unique case (state_q)
                RUN: begin
                    if (w_accept) begin
                        ex_valid_q <= 1'b1;
                        aluctl_q   <= aluctl_d;
                        in1_q      <= in1_d;
                        in2_q      <= in2_d;
                        illegal_q  <= illegal_d;
                        if (is_mult_d && (MULT_CYCLES > 1)) begin
                            state_q <= MULT;
                            cnt_q   <= C_CNT_LOAD;
                        end
                    end else begin
                        ex_valid_q <= 1'b0;
                        aluctl_q   <= C_ALU_NOP;
                        in1_q      <= 32'h0;
                        in2_q      <= 32'h0;
                        illegal_q  <= 1'b0;
                    end
                end
                MULT: begin
                    // EX holds the mult; the final occupied cycle is spent back in RUN
                    cnt_q <= cnt_q - C_CNT_ONE;
                    if (cnt_q == C_CNT_ONE) begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= RUN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_aluctl  = aluctl_q;
    assign bus.ex_in1     = in1_q;
    assign bus.ex_in2     = in2_q;
    assign bus.ex_illegal = illegal_q;
    assign bus.mult_busy  = (state_q == MULT);

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Directed scoreboard bench for alu_issue_stage (MULT_CYCLES 4 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    typedef struct packed {
        logic        rdy;
        logic        v;
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
        logic        busy;
    } obs_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    obs_t sb_q[$];

    alu_issue_stage_if b4();
    alu_issue_stage_if b1();

    alu_issue_stage #(.MULT_CYCLES(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    alu_issue_stage #(.MULT_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic rdy, input logic v, input logic [3:0] ctl,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic ill, input logic busy);
        obs_t o;
        o.rdy = rdy; o.v = v; o.ctl = ctl; o.a = a; o.b = b; o.ill = ill; o.busy = busy;
        return o;
    endfunction

    function automatic obs_t snap(input int sel);
        obs_t o;
        if (sel == 1) o = mk(1'b0, b1.ex_valid, b1.ex_aluctl, b1.ex_in1, b1.ex_in2, b1.ex_illegal, b1.mult_busy);
        else          o = mk(1'b0, b4.ex_valid, b4.ex_aluctl, b4.ex_in1, b4.ex_in2, b4.ex_illegal, b4.mult_busy);
        return o;
    endfunction

    task automatic push(input logic rdy, input logic v, input logic [3:0] ctl,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic ill, input logic busy);
        sb_q.push_back(mk(rdy, v, ctl, a, b, ill, busy));
    endtask

    task automatic set_in(input int sel, input logic vld, input logic [5:0] op, input logic [5:0] fn,
                          input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm);
        if (sel == 1) begin
            b1.id_valid = vld; b1.id_opcode = op; b1.id_funct = fn;
            b1.id_rs_data = rs; b1.id_rt_data = rt; b1.id_imm = imm;
        end else begin
            b4.id_valid = vld; b4.id_opcode = op; b4.id_funct = fn;
            b4.id_rs_data = rs; b4.id_rt_data = rt; b4.id_imm = imm;
        end
    endtask

    task automatic set_ctl(input logic stall, input logic fl);
        b4.ex_stall = stall;
        b4.flush    = fl;
    endtask

    // Samples id_ready before the edge and EX outputs 1ns after it, then scores against the queue head
    task automatic tick(input string tag, input int sel);
        obs_t got, exp;
        logic rdy;
        #1;
        rdy = (sel == 1) ? b1.id_ready : b4.id_ready;
        @(posedge clk);
        #1;
        got     = snap(sel);
        got.rdy = rdy;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed v=%b ctl=%h", tag, got.v, got.ctl);
        end else begin
            exp = sb_q.pop_front();
            assert (got === exp) else begin
                n_fail++;
                $error("FAIL %s: observed rdy=%b v=%b ctl=%h in1=%h in2=%h ill=%b busy=%b expected rdy=%b v=%b ctl=%h in1=%h in2=%h ill=%b busy=%b",
                       tag, got.rdy, got.v, got.ctl, got.a, got.b, got.ill, got.busy,
                       exp.rdy, exp.v, exp.ctl, exp.a, exp.b, exp.ill, exp.busy);
            end
        end
    endtask

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [3:0]  ctl;
        logic [31:0] in2;
        logic        ill;
    } dec_t;

    localparam logic [31:0] RT = 32'h1234_5678;
    localparam logic [31:0] SX = 32'hFFFF_FFF0;
    localparam logic [31:0] ZX = 32'h0000_FFF0;

    initial begin
        dec_t tbl[$];
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        set_ctl(1'b0, 1'b0);
        b1.ex_stall = 1'b0;
        b1.flush    = 1'b0;
        set_in(1, 1'b0, 6'h00, 6'h00, 32'h0, 32'h0, 16'h0);
        set_in(0, 1'b1, 6'h00, 6'h20, 32'd5, 32'd7, 16'h0);
        @(posedge clk);
        #1;

        // Reset held two cycles with a valid instruction waiting
        push(0, 0, 4'b0011, 0, 0, 0, 0); tick("reset0", 0);
        push(0, 0, 4'b0011, 0, 0, 0, 0); tick("reset1", 0);
        rst_n = 1'b1;
        push(1, 1, 4'b0010, 32'd5, 32'd7, 0, 0); tick("first_add", 0);
        set_in(0, 1'b0, 6'h00, 6'h00, 32'h0, 32'h0, 16'h0);
        push(1, 0, 4'b0011, 0, 0, 0, 0); tick("bubble", 0);

        tbl = '{ '{6'h00, 6'h20, 4'b0010, RT, 1'b0}, '{6'h00, 6'h22, 4'b0110, RT, 1'b0},
                 '{6'h00, 6'h24, 4'b0000, RT, 1'b0}, '{6'h00, 6'h25, 4'b0001, RT, 1'b0},
                 '{6'h00, 6'h26, 4'b1111, RT, 1'b0}, '{6'h00, 6'h27, 4'b1100, RT, 1'b0},
                 '{6'h00, 6'h2A, 4'b0111, RT, 1'b0}, '{6'h08, 6'h00, 4'b0010, SX, 1'b0},
                 '{6'h23, 6'h00, 4'b0010, SX, 1'b0}, '{6'h2B, 6'h00, 4'b0010, SX, 1'b0},
                 '{6'h0A, 6'h00, 4'b0111, SX, 1'b0}, '{6'h0C, 6'h00, 4'b0000, ZX, 1'b0},
                 '{6'h0D, 6'h00, 4'b0001, ZX, 1'b0}, '{6'h0E, 6'h00, 4'b1111, ZX, 1'b0},
                 '{6'h04, 6'h00, 4'b0110, RT, 1'b0}, '{6'h05, 6'h00, 4'b0110, RT, 1'b0},
                 '{6'h3F, 6'h00, 4'b0011, 32'h0, 1'b1}, '{6'h00, 6'h21, 4'b0011, 32'h0, 1'b1} };
        foreach (tbl[i]) begin
            set_in(0, 1'b1, tbl[i].op, tbl[i].fn, 32'h10, RT, 16'hFFF0);
            push(1, 1, tbl[i].ctl, tbl[i].ill ? 32'h0 : 32'h10, tbl[i].in2, tbl[i].ill, 0);
            tick($sformatf("decode_op%02h_fn%02h", tbl[i].op, tbl[i].fn), 0);
        end
        set_in(0, 1'b0, 6'h00, 6'h00, 32'h0, 32'h0, 16'h0);
        push(1, 0, 4'b0011, 0, 0, 0, 0); tick("sweep_idle", 0);

        // Mult followed back-to-back by sub
        set_in(0, 1'b1, 6'h00, 6'h18, 32'd3, 32'd4, 16'h0);
        push(1, 1, 4'b1000, 32'd3, 32'd4, 0, 1); tick("mult_c1", 0);
        set_in(0, 1'b1, 6'h00, 6'h22, 32'd9, 32'd2, 16'h0);
        push(0, 1, 4'b1000, 32'd3, 32'd4, 0, 1); tick("mult_c2", 0);
        push(0, 1, 4'b1000, 32'd3, 32'd4, 0, 1); tick("mult_c3", 0);
        push(0, 1, 4'b1000, 32'd3, 32'd4, 0, 0); tick("mult_c4", 0);
        push(1, 1, 4'b0110, 32'd9, 32'd2, 0, 0); tick("sub_after_mult", 0);
        set_in(0, 1'b0, 6'h00, 6'h00, 32'h0, 32'h0, 16'h0);
        push(1, 0, 4'b0011, 0, 0, 0, 0); tick("mult_idle", 0);

        // Two stalled cycles mid-mult stretch occupancy to six cycles
        set_in(0, 1'b1, 6'h00, 6'h18, 32'd6, 32'd8, 16'h0);
        push(1, 1, 4'b1000, 32'd6, 32'd8, 0, 1); tick("smult_c1", 0);
        set_in(0, 1'b0, 6'h00, 6'h00, 32'h0, 32'h0, 16'h0);
        push(0, 1, 4'b1000, 32'd6, 32'd8, 0, 1); tick("smult_c2", 0);
        set_ctl(1'b1, 1'b0);
        push(0, 1, 4'b1000, 32'd6, 32'd8, 0, 1); tick("smult_stall1", 0);
        push(0, 1, 4'b1000, 32'd6, 32'd8, 0, 1); tick("smult_stall2", 0);
        set_ctl(1'b0, 1'b0);
        push(0, 1, 4'b1000, 32'd6, 32'd8, 0, 1); tick("smult_c3", 0);
        push(0, 1, 4'b1000, 32'd6, 32'd8, 0, 0); tick("smult_c4", 0);
        push(1, 0, 4'b0011, 0, 0, 0, 0); tick("smult_idle", 0);

        // Stall on a non-mult holds EX and blocks the waiting add
        set_in(0, 1'b1, 6'h00, 6'h25, 32'hA, 32'hB, 16'h0);
        push(1, 1, 4'b0001, 32'hA, 32'hB, 0, 0); tick("or_issue", 0);
        set_in(0, 1'b1, 6'h00, 6'h20, 32'h1, 32'h2, 16'h0);
        set_ctl(1'b1, 1'b0);
        push(0, 1, 4'b0001, 32'hA, 32'hB, 0, 0); tick("or_stall", 0);
        set_ctl(1'b0, 1'b0);
        set_in(0, 1'b0, 6'h00, 6'h00, 32'h0, 32'h0, 16'h0);
        push(1, 0, 4'b0011, 0, 0, 0, 0); tick("stall_idle", 0);

        // Flush in the second mult cycle drops the pending add
        set_in(0, 1'b1, 6'h00, 6'h18, 32'd2, 32'd3, 16'h0);
        push(1, 1, 4'b1000, 32'd2, 32'd3, 0, 1); tick("fmult_c1", 0);
        set_in(0, 1'b1, 6'h00, 6'h20, 32'h1, 32'h2, 16'h0);
        set_ctl(1'b0, 1'b1);
        push(0, 0, 4'b0011, 0, 0, 0, 0); tick("flush_mult", 0);
        set_ctl(1'b0, 1'b0);
        push(1, 1, 4'b0010, 32'h1, 32'h2, 0, 0); tick("after_flush", 0);
        set_ctl(1'b1, 1'b1);
        push(0, 0, 4'b0011, 0, 0, 0, 0); tick("flush_beats_stall", 0);
        set_ctl(1'b0, 1'b0);

        // Reset in the middle of a mult
        set_in(0, 1'b1, 6'h00, 6'h18, 32'd7, 32'd7, 16'h0);
        push(1, 1, 4'b1000, 32'd7, 32'd7, 0, 1); tick("rmult_c1", 0);
        rst_n = 1'b0;
        push(0, 0, 4'b0011, 0, 0, 0, 0); tick("reset_mid_mult", 0);
        rst_n = 1'b1;
        set_in(0, 1'b0, 6'h00, 6'h00, 32'h0, 32'h0, 16'h0);
        push(1, 0, 4'b0011, 0, 0, 0, 0); tick("post_reset_idle", 0);

        // MULT_CYCLES=1 instance: mults issue every cycle, never busy
        set_in(1, 1'b1, 6'h00, 6'h18, 32'd1, 32'd2, 16'h0);
        push(1, 1, 4'b1000, 32'd1, 32'd2, 0, 0); tick("m1_mult0", 1);
        set_in(1, 1'b1, 6'h00, 6'h18, 32'd3, 32'd4, 16'h0);
        push(1, 1, 4'b1000, 32'd3, 32'd4, 0, 0); tick("m1_mult1", 1);
        set_in(1, 1'b1, 6'h00, 6'h18, 32'd5, 32'd6, 16'h0);
        push(1, 1, 4'b1000, 32'd5, 32'd6, 0, 0); tick("m1_mult2", 1);
        set_in(1, 1'b1, 6'h00, 6'h22, 32'd8, 32'd1, 16'h0);
        push(1, 1, 4'b0110, 32'd8, 32'd1, 0, 0); tick("m1_sub", 1);
        set_in(1, 1'b0, 6'h00, 6'h00, 32'h0, 32'h0, 16'h0);
        push(1, 0, 4'b0011, 0, 0, 0, 0); tick("m1_idle", 1);

        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d leftover entries, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
